// File: rtl/generador_tasa.sv
// generador_tasa: pseudo-random traffic generator and per-destination rate/checksum checker.
// Ports:
//   clk, reset_L             clock (posedge) and asynchronous active-low reset
//   start                    one-cycle pulse, starts a run from IDLE or DONE
//   mode_cont, stop          continuous mode runs until stop is high; burst mode sends num_words
//   num_words, seed          burst length and LFSR seed (seed 0 is replaced by 1)
//   rd_mask                  per-destination read enable; masked channels are not checked
//   main_full, main_wr       Main FIFO full flag and push strobe
//   main_data_in             word pushed into the Main FIFO
//   dest_empty, dest_error   destination FIFO status flags
//   dest_data_out, dest_rd   destination read data (valid the cycle after dest_rd) and pops
//   busy, done, pass         RUN/DRAIN, DONE, and the result that is valid while done
//   error_out                sticky: destination error, misrouted word or drain timeout
//   sent_count, rcvd_count   per-destination word counters, channel i at [i*CW +: CW]
module generador_tasa #(
    parameter int BW       = 6,
    parameter int DBW      = 1,
    parameter int DEST_LSB = 4,
    parameter int CW       = 16,
    parameter int TMO      = 64
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic                      start,
    input  logic                      mode_cont,
    input  logic                      stop,
    input  logic [CW-1:0]             num_words,
    input  logic [15:0]               seed,
    input  logic [(2**DBW)-1:0]       rd_mask,
    input  logic                      main_full,
    output logic                      main_wr,
    output logic [BW-1:0]             main_data_in,
    input  logic [(2**DBW)-1:0]       dest_empty,
    input  logic [(2**DBW)-1:0]       dest_error,
    input  logic [(2**DBW)*BW-1:0]    dest_data_out,
    output logic [(2**DBW)-1:0]       dest_rd,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      error_out,
    output logic [(2**DBW)*CW-1:0]    sent_count,
    output logic [(2**DBW)*CW-1:0]    rcvd_count
);
    localparam int N_DEST = 2**DBW;
    localparam int IW = $clog2(TMO + 1);
    localparam logic [CW-1:0] CMAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    logic [15:0]        r_lfsr;
    logic [CW-1:0]      r_tot;
    logic [CW-1:0]      r_sent [N_DEST];
    logic [CW-1:0]      r_rcvd [N_DEST];
    logic [BW-1:0]      r_schk [N_DEST];
    logic [BW-1:0]      r_rchk [N_DEST];
    logic [N_DEST-1:0]  r_rd_q;
    logic [IW-1:0]      r_idle;
    logic               r_err;
    logic               r_pass;

    logic [BW-1:0]      w_word;
    logic [DBW-1:0]     w_wdest;
    logic [15:0]        w_lfsr_nx;
    logic [N_DEST-1:0]  w_rd;
    logic [N_DEST-1:0]  w_bad;
    logic               w_stop;
    logic               w_push;
    logic               w_last;
    logic               w_err_set;
    logic               w_eq;
    logic               w_ok;

    // Zero means "no data" downstream, so it is never emitted.
    assign w_word    = (r_lfsr[BW-1:0] == '0) ? BW'(1) : r_lfsr[BW-1:0];
    assign w_wdest   = w_word[DEST_LSB +: DBW];
    assign w_lfsr_nx = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_stop    = mode_cont ? stop : (r_tot == num_words);
    assign w_push    = (r_state == S_RUN) & ~main_full & ~w_stop;
    // Leave RUN on the same edge as the final burst push, so no extra idle RUN cycle.
    assign w_last    = w_stop | (~mode_cont & w_push & ((r_tot + 1'b1) == num_words));
    assign busy      = (r_state == S_RUN) | (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign w_rd      = busy ? (rd_mask & ~dest_empty & ~dest_error) : '0;
    assign w_err_set = busy & ((|dest_error) | (|w_bad));

    assign main_wr      = w_push;
    assign main_data_in = w_push ? w_word : '0;
    assign dest_rd      = w_rd;
    assign pass         = r_pass;
    assign error_out    = r_err;

    always_comb begin
        w_bad = '0;
        w_eq  = 1'b1;
        w_ok  = 1'b1;
        for (int i = 0; i < N_DEST; i++) begin
            w_bad[i] = r_rd_q[i] & (dest_data_out[i*BW + DEST_LSB +: DBW] != DBW'(i));
            w_eq = w_eq & (~rd_mask[i] | (r_sent[i] == r_rcvd[i]));
            w_ok = w_ok & (~rd_mask[i] | (r_schk[i] == r_rchk[i]))
                        & (r_sent[i] != CMAX) & (r_rcvd[i] != CMAX);
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_DEST; g++) begin : g_out
            assign sent_count[g*CW +: CW] = r_sent[g];
            assign rcvd_count[g*CW +: CW] = r_rcvd[g];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= S_IDLE;
            r_lfsr  <= 16'h0001;
            r_tot   <= '0;
            r_rd_q  <= '0;
            r_idle  <= '0;
            r_err   <= 1'b0;
            r_pass  <= 1'b0;
            for (int i = 0; i < N_DEST; i++) begin
                r_sent[i] <= '0;
                r_rcvd[i] <= '0;
                r_schk[i] <= '0;
                r_rchk[i] <= '0;
            end
        end else begin
            r_rd_q <= w_rd;
            if (w_err_set) r_err <= 1'b1;
            if (w_push) begin
                r_lfsr <= w_lfsr_nx;
                if (r_tot != CMAX) r_tot <= r_tot + 1'b1;
                if (r_sent[w_wdest] != CMAX) r_sent[w_wdest] <= r_sent[w_wdest] + 1'b1;
                r_schk[w_wdest] <= r_schk[w_wdest] ^ w_word;
            end
            for (int i = 0; i < N_DEST; i++) begin
                if (r_rd_q[i]) begin
                    if (r_rcvd[i] != CMAX) r_rcvd[i] <= r_rcvd[i] + 1'b1;
                    r_rchk[i] <= r_rchk[i] ^ dest_data_out[i*BW +: BW];
                end
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_lfsr  <= (seed == 16'h0) ? 16'h0001 : seed;
                        r_tot   <= '0;
                        r_rd_q  <= '0;
                        r_err   <= 1'b0;
                        r_pass  <= 1'b0;
                        for (int i = 0; i < N_DEST; i++) begin
                            r_sent[i] <= '0;
                            r_rcvd[i] <= '0;
                            r_schk[i] <= '0;
                            r_rchk[i] <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        r_state <= S_DRAIN;
                        r_idle  <= '0;
                    end
                end
                S_DRAIN: begin
                    r_idle <= (|r_rd_q) ? '0 : r_idle + 1'b1;
                    // Finish only when nothing is issued or returning, so no word is lost.
                    if (w_eq && r_rd_q == '0 && w_rd == '0) begin
                        r_state <= S_DONE;
                        r_pass  <= w_ok & ~r_err & ~w_err_set;
                    end else if (r_rd_q == '0 && r_idle == IW'(TMO - 1)) begin
                        r_state <= S_DONE;
                        r_err   <= 1'b1;
                        r_pass  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
